keypoint_write_arbiter: RTL and testbench

- Shares one keypoint SRAM between the two scale-lane keypoint producers of the detect/filter stage (lane 0 = lower DoG triple, lane 1 = upper DoG triple).
- Each lane pushes {row, col} words into a private FIFO. A round-robin arbiter drains the FIFOs into the SRAM, one write per cycle, at consecutive addresses. Each word is tagged with its lane.
- Session control: start/flush/done handshake with the top-level SIFT sequencer. Provides keypoint count and overflow status for the downstream descriptor stage.

---
 rtl/keypoint_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_keypoint_write_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypoint_write_arbiter.sv
// Merges the keypoint streams of the two scale-lane producers into one keypoint SRAM.
// Each lane has a private FIFO; a round-robin arbiter drains them one write per cycle.
module keypoint_write_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12,
  parameter int MAX_KP     = 4096,
  parameter int KP_W       = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic              req_0,
  input  logic [KP_W-1:0]   din_0,
  output logic              ready_0,
  input  logic              req_1,
  input  logic [KP_W-1:0]   din_1,
  output logic              ready_1,
  output logic              kp_we,
  output logic [ADDR_W-1:0] kp_addr,
  output logic [KP_W:0]     kp_din,
  output logic [ADDR_W:0]   kp_count,
  output logic              overflow,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [KP_W-1:0]  mem    [2][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr [2];
  logic [PTR_W-1:0] rd_ptr [2];
  logic [CNT_W-1:0] cnt    [2];
  logic [KP_W-1:0]  din_v  [2];

  logic [1:0] req_v, ready_v, push, pop, not_empty;
  logic       grant, last_grant, enter_run;

  assign req_v    = {req_1, req_0};
  assign din_v[0] = din_0;
  assign din_v[1] = din_1;

  // Handshake: a word moves on the edge where req && ready; ready depends only on
  // registered state and flush, never on req, and a refused producer holds req/din.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      not_empty[i] = (cnt[i] != '0);
      ready_v[i]   = (state == RUN) && !flush && (cnt[i] < CNT_W'(FIFO_DEPTH));
      push[i]      = req_v[i] && ready_v[i];
    end
  end

  assign ready_0 = ready_v[0];
  assign ready_1 = ready_v[1];

  // last_grant holds the lane served most recently; reset to 1 so lane 0 wins first.
  always_comb begin
    grant = 1'b0;
    pop   = 2'b00;
    if ((state == RUN) || (state == DRAIN)) begin
      if (&not_empty) grant = ~last_grant;
      else            grant = not_empty[1];
      if (|not_empty) pop = grant ? 2'b10 : 2'b01;
    end
  end

  assign enter_run = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (flush) state_nxt = DRAIN;
      DRAIN:   if (not_empty == 2'b00) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= din_v[i];
    end
  end

  // At capacity a pop still frees the FIFO slot but the word is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kp_we      <= 1'b0;
      kp_addr    <= '0;
      kp_din     <= '0;
      kp_count   <= '0;
      overflow   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      kp_we <= 1'b0;
      if (enter_run) begin
        kp_count   <= '0;
        overflow   <= 1'b0;
        last_grant <= 1'b1;
      end
      if (|pop) begin
        last_grant <= grant;
        if (kp_count < (ADDR_W+1)'(MAX_KP)) begin
          kp_we    <= 1'b1;
          kp_addr  <= kp_count[ADDR_W-1:0];
          kp_din   <= {grant, mem[grant][rd_ptr[grant]]};
          kp_count <= kp_count + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_keypoint_write_arbiter.sv
// Bench for keypoint_write_arbiter: queue-based reference model compared every cycle,
// plus directed sessions with hand-computed expectations.
module tb_keypoint_write_arbiter;

  localparam int FD = 4;
  localparam int AW = 4;
  localparam int MK = 16;
  localparam int KW = 19;

  // clock / reset / DUT
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, flush = 1'b0;
  logic          req_0 = 1'b0, req_1 = 1'b0;
  logic [KW-1:0] din_0 = '0, din_1 = '0;
  logic          ready_0, ready_1, kp_we, overflow, busy, done;
  logic [AW-1:0] kp_addr;
  logic [KW:0]   kp_din;
  logic [AW:0]   kp_count;

  always #5 clk = ~clk;

  keypoint_write_arbiter #(.FIFO_DEPTH(FD), .ADDR_W(AW), .MAX_KP(MK), .KP_W(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .req_0(req_0), .din_0(din_0), .ready_0(ready_0),
    .req_1(req_1), .din_1(din_1), .ready_1(ready_1),
    .kp_we(kp_we), .kp_addr(kp_addr), .kp_din(kp_din), .kp_count(kp_count),
    .overflow(overflow), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // reference model: 0 idle, 1 run, 2 drain, 3 done
  int            m_state = 0;
  int            m_last  = 1;
  logic [KW-1:0] mq0[$];
  logic [KW-1:0] mq1[$];
  bit            m_we = 0;
  int            m_addr = 0;
  logic [KW:0]   m_din = '0;
  int            m_count = 0;
  bit            m_ovf = 0;

  function automatic bit model_ready(input int lane);
    if (m_state != 1 || flush) return 1'b0;
    return (lane == 0) ? (mq0.size() < FD) : (mq1.size() < FD);
  endfunction

  initial forever begin : model
    bit p0, p1, empty_pre;
    int lane;
    logic [KW-1:0] w;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_state = 0; m_last = 1; mq0.delete(); mq1.delete();
      m_we = 0; m_addr = 0; m_din = '0; m_count = 0; m_ovf = 0;
    end else begin
      p0 = req_0 && model_ready(0);
      p1 = req_1 && model_ready(1);
      empty_pre = (mq0.size() == 0) && (mq1.size() == 0);
      lane = -1;
      w = '0;
      if (m_state == 1 || m_state == 2) begin
        if (mq0.size() > 0 && mq1.size() > 0) lane = 1 - m_last;
        else if (mq0.size() > 0)              lane = 0;
        else if (mq1.size() > 0)              lane = 1;
        if (lane == 0) w = mq0.pop_front();
        if (lane == 1) w = mq1.pop_front();
        if (lane >= 0) m_last = lane;
      end
      m_we = 0;
      if (lane >= 0) begin
        if (m_count < MK) begin
          m_we = 1; m_addr = m_count; m_din = {lane[0], w}; m_count++;
        end else m_ovf = 1;
      end
      if (p0) mq0.push_back(din_0);
      if (p1) mq1.push_back(din_1);
      case (m_state)
        0, 3: if (start) begin m_state = 1; m_count = 0; m_ovf = 0; m_last = 1; end
        1:    if (flush) m_state = 2;
        2:    if (empty_pre) m_state = 3;
        default: m_state = 0;
      endcase
    end
  end

  // scoreboard watch for the held lane-1 word
  bit          watch_en = 0;
  logic [KW:0] watch_word = '0;
  int          watch_hits = 0;

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    check("kp_we",    32'(kp_we),    32'(m_we));
    check("kp_addr",  32'(kp_addr),  32'(m_addr));
    check("kp_din",   32'(kp_din),   32'(m_din));
    check("kp_count", 32'(kp_count), 32'(m_count));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("busy",     32'(busy),     32'(m_state == 1 || m_state == 2));
    check("done",     32'(done),     32'(m_state == 3));
    check("ready_0",  32'(ready_0),  32'(model_ready(0)));
    check("ready_1",  32'(ready_1),  32'(model_ready(1)));
    if (watch_en && kp_we && kp_din == watch_word) watch_hits++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin tick(); n++; end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic push_lane0(input int n, input int base);
    int guard = 0;
    for (int k = 0; k < n; k++) begin
      bit acc = 0;
      req_0 = 1'b1;
      din_0 = {9'(base + k), 10'(3 * k)};
      while (!acc && guard < 500) begin
        @(negedge clk); acc = ready_0; tick(); guard++;
      end
    end
    req_0 = 1'b0;
    check("push_lane0_bounded", 32'(guard < 500), 32'd1);
  endtask

  function automatic logic [KW-1:0] w0(input int k);
    return {9'(k + 1), 10'(2 * k)};
  endfunction

  function automatic logic [KW-1:0] w1(input int k);
    return {9'(100 + k), 10'(300 + k)};
  endfunction

  initial begin
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_kp_we", 32'(kp_we), 32'd0);
    check("rst_kp_count", 32'(kp_count), 32'd0);
    check("rst_ready_0", 32'(ready_0), 32'd0);
    tick(); rst = 1'b0;
    tick();

    // single lane: (5,7) then (5,9)
    pulse_start();
    req_0 = 1'b1; din_0 = {9'd5, 10'd7};
    tick();
    din_0 = {9'd5, 10'd9};
    tick();
    req_0 = 1'b0;
    @(negedge clk);
    check("single_we0", 32'(kp_we), 32'd1);
    check("single_addr0", 32'(kp_addr), 32'd0);
    check("single_din0", 32'(kp_din), 32'({1'b0, 9'd5, 10'd7}));
    tick();
    @(negedge clk);
    check("single_addr1", 32'(kp_addr), 32'd1);
    check("single_din1", 32'(kp_din), 32'({1'b0, 9'd5, 10'd9}));
    check("single_count", 32'(kp_count), 32'd2);
    pulse_flush();
    wait_done(20);

    // contention with backpressure on lane 1
    pulse_start();
    begin
      int i0 = 0, i1 = 0, cyc = 0;
      bit a0, a1, saw_full = 0;
      req_0 = 1'b1; req_1 = 1'b1; din_0 = w0(0); din_1 = w1(0);
      while ((i0 < 8 || i1 < 8) && cyc < 100) begin
        @(negedge clk);
        a0 = req_0 && ready_0;
        a1 = req_1 && ready_1;
        if (req_1 && !ready_1 && !watch_en) begin
          watch_en = 1; watch_word = {1'b1, din_1}; saw_full = 1;
        end
        tick(); cyc++;
        if (a0) begin i0++; if (i0 < 8) din_0 = w0(i0); else req_0 = 1'b0; end
        if (a1) begin i1++; if (i1 < 8) din_1 = w1(i1); else req_1 = 1'b0; end
      end
      check("contention_bounded", 32'(cyc < 100), 32'd1);
      check("saw_ready1_low", 32'(saw_full), 32'd1);
    end
    pulse_flush();
    wait_done(50);
    check("contention_count", 32'(kp_count), 32'd16);
    check("contention_no_ovf", 32'(overflow), 32'd0);
    check("held_word_once", 32'(watch_hits), 32'd1);
    watch_en = 0;

    // flush / drain with 3 entries
    pulse_start();
    req_0 = 1'b1; din_0 = 19'h0AAAA; req_1 = 1'b1; din_1 = 19'h0BBBB;
    tick();
    req_1 = 1'b0; din_0 = 19'h0CCCC;
    tick();
    din_0 = 19'h0DDDD; flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("drain_ready_0", 32'(ready_0), 32'd0);
    check("drain_ready_1", 32'(ready_1), 32'd0);
    check("drain_busy", 32'(busy), 32'd1);
    check("rr_din_lane1", 32'(kp_din), 32'({1'b1, 19'h0BBBB}));
    check("rr_addr1", 32'(kp_addr), 32'd1);
    wait_done(20);
    req_0 = 1'b0;
    check("drain_count", 32'(kp_count), 32'd3);
    check("drain_busy_low", 32'(busy), 32'd0);
    req_0 = 1'b1; din_0 = 19'h0EEEE;
    repeat (3) tick();
    req_0 = 1'b0;
    check("done_refuses", 32'(kp_count), 32'd3);

    // capacity: 20 keypoints into a 16-entry SRAM
    pulse_start();
    push_lane0(20, 10);
    pulse_flush();
    wait_done(20);
    check("cap_count", 32'(kp_count), 32'd16);
    check("cap_overflow", 32'(overflow), 32'd1);
    check("cap_last_addr", 32'(kp_addr), 32'd15);
    pulse_start();
    @(negedge clk);
    check("restart_count", 32'(kp_count), 32'd0);
    check("restart_ovf", 32'(overflow), 32'd0);

    // async reset mid-drain
    req_0 = 1'b1; req_1 = 1'b1; din_0 = 19'h00111; din_1 = 19'h00222;
    repeat (3) tick();
    req_0 = 1'b0; req_1 = 1'b0;
    pulse_flush();
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_we", 32'(kp_we), 32'd0);
    check("arst_count", 32'(kp_count), 32'd0);
    check("arst_addr", 32'(kp_addr), 32'd0);
    check("arst_din", 32'(kp_din), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    tick(); rst = 1'b0;
    tick();
    pulse_start();
    repeat (3) tick();
    check("post_rst_empty", 32'(kp_count), 32'd0);
    pulse_flush();
    wait_done(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
